// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared types and defaults for the PRBS checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] DEFAULT_TAPS = 8'b10111000;

endpackage

// File: rtl/prbs_popcount.sv
// rtl/prbs_popcount.sv - combinational population count of a LEN-bit word.
module prbs_popcount #(
  parameter int LEN = 8
) (
  input  logic [LEN-1:0]             bits,
  output logic [$clog2(LEN+1)-1:0]   count
);

  localparam int CW = $clog2(LEN + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < LEN; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising Galois LFSR checker with flywheel,
// error statistics and windowed loss-of-lock detection.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int             LEN        = 8,
  parameter logic [LEN-1:0] TAPS       = DEFAULT_TAPS,
  parameter int             LOCK_CNT   = 4,
  parameter int             WIN        = 256,
  parameter int             ERR_THRESH = 8,
  parameter int             CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [LEN-1:0]   din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_words,
  output logic [CNT_W-1:0] err_bits,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam int PW = $clog2(LEN + 1);

  function automatic logic [LEN-1:0] step(input logic [LEN-1:0] x);
    return {1'b0, x[LEN-1:1]} ^ (x[0] ? TAPS : '0);
  endfunction

  state_t         state;
  logic [LEN-1:0] exp_word;
  logic [MW-1:0]  match_cnt;
  logic [WW-1:0]  win_cnt;
  logic [EW-1:0]  win_err;
  logic [EW-1:0]  win_err_nxt;
  logic [PW-1:0]  bit_errs;
  logic           mismatch;
  logic           checking;
  logic [CNT_W:0] bits_sum;

  assign mismatch = (din != exp_word);
  assign checking = en && (state == LOCKED);
  assign locked   = (state == LOCKED);
  assign bits_sum = {1'b0, err_bits} + (CNT_W + 1)'(bit_errs);

  prbs_popcount #(.LEN(LEN)) u_popcount (
    .bits  (din ^ exp_word),
    .count (bit_errs)
  );

  // The wrap word opens a fresh window, so its own error is the first one counted there.
  always_comb begin
    if (win_cnt == WW'(WIN - 1)) win_err_nxt = EW'(mismatch);
    else                         win_err_nxt = win_err + EW'(mismatch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEEK;
      exp_word  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (en) begin
        unique case (state)
          SEEK: begin
            exp_word  <= step(din);
            match_cnt <= '0;
            if (din != '0) state <= VERIFY;
          end
          VERIFY: begin
            exp_word <= step(din);
            if (!mismatch) begin
              match_cnt <= match_cnt + MW'(1);
              if (match_cnt == MW'(LOCK_CNT - 1)) begin
                state   <= LOCKED;
                win_cnt <= '0;
                win_err <= '0;
              end
            end else begin
              match_cnt <= '0;
              if (din == '0) state <= SEEK;
            end
          end
          LOCKED: begin
            exp_word <= step(exp_word);
            err      <= mismatch;
            win_cnt  <= (win_cnt == WW'(WIN - 1)) ? '0 : win_cnt + WW'(1);
            win_err  <= win_err_nxt;
            if (win_err_nxt == EW'(ERR_THRESH)) state <= SEEK;
          end
          default: state <= SEEK;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_words <= '0;
      err_bits  <= '0;
      word_cnt  <= '0;
    end else if (clr_cnt) begin
      err_words <= '0;
      err_bits  <= '0;
      word_cnt  <= '0;
    end else if (checking) begin
      if (!(&word_cnt)) word_cnt <= word_cnt + CNT_W'(1);
      if (mismatch) begin
        if (!(&err_words)) err_words <= err_words + CNT_W'(1);
        err_bits <= bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - self-checking bench for prbs_checker.
module tb_prbs_checker;

  localparam int LOCK_CNT   = 4;
  localparam int WIN        = 256;
  localparam int ERR_THRESH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr_cnt = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        locked, err;
  logic [31:0] err_words, err_bits, word_cnt;
  logic        locked4, err4;
  logic [3:0]  err_words4, err_bits4, word_cnt4;

  prbs_checker dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr_cnt(clr_cnt),
    .locked(locked), .err(err), .err_words(err_words), .err_bits(err_bits),
    .word_cnt(word_cnt)
  );

  prbs_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr_cnt(clr_cnt),
    .locked(locked4), .err(err4), .err_words(err_words4), .err_bits(err_bits4),
    .word_cnt(word_cnt4)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: lock = last LOCK_CNT+1 unlocked words form an LFSR chain.
  bit         m_locked, m_err;
  longint     m_ew, m_eb, m_wc;
  int         m_idx, m_werr;
  logic [7:0] m_exp;
  logic [7:0] hist[$];
  logic [7:0] g_state;
  bit         chk_en = 1'b0;

  function automatic logic [7:0] f(input logic [7:0] x);
    return {1'b0, x[7:1]} ^ (x[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit chain_ok();
    if (hist[0] == 8'h00) return 1'b0;
    for (int i = 0; i + 1 < hist.size(); i++)
      if (hist[i+1] != f(hist[i])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input longint act, input longint want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_err = 1'b0;
    m_ew = 0; m_eb = 0; m_wc = 0;
    m_idx = 0; m_werr = 0; m_exp = 8'h00;
    hist.delete();
  endtask

  task automatic model_step(input bit e, input logic [7:0] d, input bit c);
    m_err = 1'b0;
    if (e) begin
      if (m_locked) begin
        m_wc++;
        if ((m_idx % WIN) == WIN - 1) m_werr = 0;
        if (d != m_exp) begin
          m_err = 1'b1;
          m_ew++;
          m_eb += $countones(d ^ m_exp);
          m_werr++;
        end
        m_idx++;
        m_exp = f(m_exp);
        if (m_werr == ERR_THRESH) begin
          m_locked = 1'b0;
          hist.delete();
        end
      end else begin
        hist.push_back(d);
        if (hist.size() > LOCK_CNT + 1) void'(hist.pop_front());
        if (hist.size() == LOCK_CNT + 1 && chain_ok()) begin
          m_locked = 1'b1;
          m_idx    = 0;
          m_werr   = 0;
          m_exp    = f(d);
        end
      end
    end
    if (c) begin
      m_ew = 0; m_eb = 0; m_wc = 0;
    end
  endtask

  task automatic send(input bit e, input logic [7:0] d, input bit c);
    en = e; din = d; clr_cnt = c;
    @(posedge clk);
    model_step(e, d, c);
    @(negedge clk);
  endtask

  task automatic word(input logic [7:0] mask, input bit c);
    send(1'b1, g_state ^ mask, c);
    g_state = f(g_state);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("locked",     locked,     m_locked);
      chk("err",        err,        m_err);
      chk("err_words",  err_words,  sat(m_ew, 32));
      chk("err_bits",   err_bits,   sat(m_eb, 32));
      chk("word_cnt",   word_cnt,   sat(m_wc, 32));
      chk("locked4",    locked4,    m_locked);
      chk("err_words4", err_words4, sat(m_ew, 4));
      chk("err_bits4",  err_bits4,  sat(m_eb, 4));
      chk("word_cnt4",  word_cnt4,  sat(m_wc, 4));
    end
  end

  initial begin
    logic [7:0] mask;
    bit         c;

    chk("model_f_ff", f(8'hFF), 8'hC7);
    chk("model_f_c7", f(8'hC7), 8'hDB);

    model_reset();
    #3;
    chk("rst_locked",    locked,    0);
    chk("rst_err",       err,       0);
    chk("rst_err_words", err_words, 0);
    chk("rst_word_cnt",  word_cnt,  0);
    do_reset();

    g_state = 8'hFF;
    for (int i = 1; i <= 5; i++) begin
      word(8'h00, 1'b0);
      chk("lock_after_word", locked, (i == 5) ? 1 : 0);
    end
    repeat (10) word(8'h00, 1'b0);
    chk("word_cnt_clean", word_cnt, 10);
    chk("clean_no_errs",  err_words, 0);

    word(8'h01, 1'b0);
    chk("bit0_err",       err,       1);
    chk("bit0_err_words", err_words, 1);
    chk("bit0_err_bits",  err_bits,  1);
    chk("bit0_locked",    locked,    1);
    word(8'h00, 1'b0);
    chk("err_one_cycle",  err,       0);
    repeat (5) word(8'h00, 1'b0);
    chk("no_propagation", err_words, 1);

    word(8'hFF, 1'b0);
    chk("inv_err_bits",  err_bits,  9);
    chk("inv_err_words", err_words, 2);

    word(8'h10, 1'b1);
    chk("clr_err_words", err_words, 0);
    chk("clr_err_bits",  err_bits,  0);
    chk("clr_word_cnt",  word_cnt,  0);
    chk("clr_err_pulse", err,       1);

    do_reset();
    g_state = 8'h5A;
    repeat (5) word(8'h00, 1'b0);
    chk("relock", locked, 1);
    repeat (3 * WIN - 1) begin
      if (((m_idx + 1) % WIN) < 7) word(8'(1 << $urandom_range(7)), 1'b0);
      else                         word(8'h00, 1'b0);
    end
    chk("seven_per_win_locked", locked,     1);
    chk("twenty_errs",          err_words,  20);
    chk("twenty_errs_sat4",     err_words4, 15);
    repeat (7) word(8'h80, 1'b0);
    chk("seven_in_win_locked", locked, 1);
    word(8'h80, 1'b0);
    chk("eighth_loses_lock", locked, 0);

    repeat (20) send(1'b1, 8'h00, 1'b0);
    chk("zero_stays_seek", locked, 0);

    do_reset();
    g_state = 8'h33;
    for (int i = 1; i <= 5; i++) begin
      send(1'b0, 8'($urandom), 1'b0);
      word(8'h00, 1'b0);
      chk("toggle_lock", locked, (i == 5) ? 1 : 0);
    end
    repeat (6) begin
      send(1'b0, 8'($urandom), 1'b0);
      word(8'h00, 1'b0);
    end
    chk("toggle_no_errs", err_words, 0);

    repeat (3000) begin
      if ($urandom_range(499) == 0) g_state = 8'($urandom_range(255, 1));
      c = ($urandom_range(199) == 0);
      if ($urandom_range(3) == 0) begin
        send(1'b0, 8'($urandom), c);
      end else begin
        mask = ($urandom_range(40) == 0) ? 8'($urandom) : 8'h00;
        word(mask, c);
      end
    end

    do_reset();
    g_state = 8'hA5;
    repeat (6) word(8'h00, 1'b0);
    word(8'h03, 1'b0);
    chk("pre_async_locked", locked, 1);
    chk("pre_async_err",    err,    1);
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async_locked",    locked,    0);
    chk("async_err",       err,       0);
    chk("async_err_words", err_words, 0);
    chk("async_err_bits",  err_bits,  0);
    chk("async_word_cnt",  word_cnt,  0);
    model_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (3) word(8'h00, 1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
